// File: rtl/arith_vector_checker.sv
// rtl/arith_vector_checker.sv - replays stored vectors into the arithmetic encoder and checks its range/low outputs
module arith_vector_checker #(
  parameter int RANGE_WIDTH    = 16,
  parameter int LOW_WIDTH      = 24,
  parameter int SYMBOL_WIDTH   = 4,
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int LATENCY        = 4,
  parameter int ISSUE_INTERVAL = 2,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                    general_clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [RANGE_WIDTH-1:0]  load_fl,
  input  logic [RANGE_WIDTH-1:0]  load_fh,
  input  logic [SYMBOL_WIDTH-1:0] load_symbol,
  input  logic [SYMBOL_WIDTH:0]   load_nsyms,
  input  logic [LOW_WIDTH-1:0]    load_exp_low,
  input  logic [RANGE_WIDTH-1:0]  load_exp_range,
  input  logic [ADDR_WIDTH:0]     num_vectors,
  input  logic                    start,
  output logic                    enc_reset,
  output logic [RANGE_WIDTH-1:0]  enc_fl,
  output logic [RANGE_WIDTH-1:0]  enc_fh,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol,
  output logic [SYMBOL_WIDTH:0]   enc_nsyms,
  input  logic [RANGE_WIDTH-1:0]  enc_range,
  input  logic [LOW_WIDTH-1:0]    enc_low,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_WIDTH-1:0]    mismatch_count,
  output logic [ADDR_WIDTH-1:0]   first_fail_idx,
  output logic                    first_fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int IW = $clog2(ISSUE_INTERVAL + 1);
  localparam logic [IW-1:0]       ISS_LAST = IW'(ISSUE_INTERVAL - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_N  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_N    = (ADDR_WIDTH + 1)'(1);

  logic [RANGE_WIDTH-1:0]  mem_fl_q    [DEPTH];
  logic [RANGE_WIDTH-1:0]  mem_fh_q    [DEPTH];
  logic [SYMBOL_WIDTH-1:0] mem_sym_q   [DEPTH];
  logic [SYMBOL_WIDTH:0]   mem_ns_q    [DEPTH];
  logic [LOW_WIDTH-1:0]    mem_low_q   [DEPTH];
  logic [RANGE_WIDTH-1:0]  mem_range_q [DEPTH];

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     n_q, n_d;
  logic [ADDR_WIDTH-1:0]   vec_q, vec_d;
  logic [IW-1:0]           iss_q, iss_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    ffv_q, ffv_d;
  logic [ADDR_WIDTH-1:0]   ffi_q, ffi_d;
  logic                    last_cmp_q, last_cmp_d;
  logic [LATENCY-1:0]      dl_valid_q, dl_valid_d;
  logic [LATENCY-1:0]      dl_last_q, dl_last_d;
  logic [ADDR_WIDTH-1:0]   dl_idx_q   [LATENCY];
  logic [ADDR_WIDTH-1:0]   dl_idx_d   [LATENCY];
  logic [LOW_WIDTH-1:0]    dl_low_q   [LATENCY];
  logic [LOW_WIDTH-1:0]    dl_low_d   [LATENCY];
  logic [RANGE_WIDTH-1:0]  dl_range_q [LATENCY];
  logic [RANGE_WIDTH-1:0]  dl_range_d [LATENCY];

  logic drive, first_cycle, last_vec, cmp_valid, cmp_bad, cmp_last, load_ok;

  assign load_ok = load_en && (state_q == S_IDLE || state_q == S_DONE);

  // Vector memory is deliberately left out of reset so vectors survive a run abort.
  always_ff @(posedge general_clk) begin
    if (load_ok) begin
      mem_fl_q[load_addr]    <= load_fl;
      mem_fh_q[load_addr]    <= load_fh;
      mem_sym_q[load_addr]   <= load_symbol;
      mem_ns_q[load_addr]    <= load_nsyms;
      mem_low_q[load_addr]   <= load_exp_low;
      mem_range_q[load_addr] <= load_exp_range;
    end
  end

  always_comb begin
    drive       = (state_q == S_RUN);
    first_cycle = drive && (iss_q == '0);
    last_vec    = drive && ({1'b0, vec_q} == (n_q - ONE_N));
    cmp_valid   = dl_valid_q[LATENCY-1];
    cmp_last    = cmp_valid && dl_last_q[LATENCY-1];
    cmp_bad     = cmp_valid && ((enc_range != dl_range_q[LATENCY-1]) ||
                                (enc_low != dl_low_q[LATENCY-1]));

    state_d    = state_q;
    n_d        = n_q;
    vec_d      = vec_q;
    iss_d      = iss_q;
    cnt_d      = cnt_q;
    ffv_d      = ffv_q;
    ffi_d      = ffi_q;
    last_cmp_d = last_cmp_q;

    // Only the first drive cycle of a vector launches a compare token.
    dl_valid_d[0] = first_cycle;
    dl_last_d[0]  = last_vec;
    dl_idx_d[0]   = vec_q;
    dl_low_d[0]   = mem_low_q[vec_q];
    dl_range_d[0] = mem_range_q[vec_q];
    for (int i = 1; i < LATENCY; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_last_d[i]  = dl_last_q[i-1];
      dl_idx_d[i]   = dl_idx_q[i-1];
      dl_low_d[i]   = dl_low_q[i-1];
      dl_range_d[i] = dl_range_q[i-1];
    end

    if (cmp_bad) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
      if (!ffv_q) begin
        ffv_d = 1'b1;
        ffi_d = dl_idx_q[LATENCY-1];
      end
    end
    if (cmp_last) last_cmp_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d        = (num_vectors > DEPTH_N) ? DEPTH_N : num_vectors;
          cnt_d      = '0;
          ffv_d      = 1'b0;
          ffi_d      = '0;
          last_cmp_d = 1'b0;
          vec_d      = '0;
          iss_d      = '0;
          state_d    = (num_vectors == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (iss_q == ISS_LAST) begin
          iss_d = '0;
          if (last_vec) state_d = S_DRAIN;
          else          vec_d   = vec_q + ADDR_WIDTH'(1);
        end else begin
          iss_d = iss_q + IW'(1);
        end
      end
      S_DRAIN: begin
        // With a short latency the final compare may already have happened during RUN.
        if (cmp_last || last_cmp_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge general_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      vec_q      <= '0;
      iss_q      <= '0;
      cnt_q      <= '0;
      ffv_q      <= 1'b0;
      ffi_q      <= '0;
      last_cmp_q <= 1'b0;
      dl_valid_q <= '0;
      dl_last_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_idx_q[i]   <= '0;
        dl_low_q[i]   <= '0;
        dl_range_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      vec_q      <= vec_d;
      iss_q      <= iss_d;
      cnt_q      <= cnt_d;
      ffv_q      <= ffv_d;
      ffi_q      <= ffi_d;
      last_cmp_q <= last_cmp_d;
      dl_valid_q <= dl_valid_d;
      dl_last_q  <= dl_last_d;
      dl_idx_q   <= dl_idx_d;
      dl_low_q   <= dl_low_d;
      dl_range_q <= dl_range_d;
    end
  end

  assign enc_fl           = drive ? mem_fl_q[vec_q]  : '0;
  assign enc_fh           = drive ? mem_fh_q[vec_q]  : '0;
  assign enc_symbol       = drive ? mem_sym_q[vec_q] : '0;
  assign enc_nsyms        = drive ? mem_ns_q[vec_q]  : '0;
  assign busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign enc_reset        = !busy;
  assign done             = (state_q == S_DONE);
  assign pass             = done && (cnt_q == '0);
  assign mismatch_count   = cnt_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_arith_vector_checker.sv
// tb/tb_arith_vector_checker.sv - table-driven scoreboard bench for arith_vector_checker
module tb_arith_vector_checker;

  localparam int RW = 16, LW = 24, SW = 4, DEPTH = 16, AW = 4, LAT = 4, II = 2, CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, load_en = 1'b0, start = 1'b0, corrupt = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [RW-1:0] load_fl = '0, load_fh = '0, load_exp_range = '0;
  logic [SW-1:0] load_symbol = '0;
  logic [SW:0]   load_nsyms = '0;
  logic [LW-1:0] load_exp_low = '0;
  logic [AW:0]   num_vectors = '0;

  logic          enc_reset, busy, done, pass, first_fail_valid;
  logic [RW-1:0] enc_fl, enc_fh, enc_range;
  logic [SW-1:0] enc_symbol;
  logic [SW:0]   enc_nsyms;
  logic [LW-1:0] enc_low;
  logic [CW-1:0] mismatch_count;
  logic [AW-1:0] first_fail_idx;

  logic          s_enc_reset, s_busy, s_done, s_pass, s_ffv;
  logic [RW-1:0] s_enc_fl, s_enc_fh, s_enc_range;
  logic [SW-1:0] s_enc_symbol;
  logic [SW:0]   s_enc_nsyms;
  logic [LW-1:0] s_enc_low;
  logic [2:0]    s_cnt;
  logic [AW-1:0] s_ffi;

  arith_vector_checker #(.RANGE_WIDTH(RW), .LOW_WIDTH(LW), .SYMBOL_WIDTH(SW), .DEPTH(DEPTH),
    .ADDR_WIDTH(AW), .LATENCY(LAT), .ISSUE_INTERVAL(II), .CNT_WIDTH(CW)) dut (
    .general_clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_fl(load_fl), .load_fh(load_fh), .load_symbol(load_symbol), .load_nsyms(load_nsyms),
    .load_exp_low(load_exp_low), .load_exp_range(load_exp_range), .num_vectors(num_vectors),
    .start(start), .enc_reset(enc_reset), .enc_fl(enc_fl), .enc_fh(enc_fh),
    .enc_symbol(enc_symbol), .enc_nsyms(enc_nsyms), .enc_range(enc_range), .enc_low(enc_low),
    .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid));

  // Second instance: single-cycle issue and a 3-bit counter to exercise saturation.
  arith_vector_checker #(.RANGE_WIDTH(RW), .LOW_WIDTH(LW), .SYMBOL_WIDTH(SW), .DEPTH(DEPTH),
    .ADDR_WIDTH(AW), .LATENCY(LAT), .ISSUE_INTERVAL(1), .CNT_WIDTH(3)) dut_sat (
    .general_clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_fl(load_fl), .load_fh(load_fh), .load_symbol(load_symbol), .load_nsyms(load_nsyms),
    .load_exp_low(load_exp_low), .load_exp_range(load_exp_range), .num_vectors(num_vectors),
    .start(start), .enc_reset(s_enc_reset), .enc_fl(s_enc_fl), .enc_fh(s_enc_fh),
    .enc_symbol(s_enc_symbol), .enc_nsyms(s_enc_nsyms), .enc_range(s_enc_range),
    .enc_low(s_enc_low), .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch_count(s_cnt),
    .first_fail_idx(s_ffi), .first_fail_valid(s_ffv));

  // Loopback encoder stubs: range=fh, low=fl, four cycles later.
  logic [RW-1:0] m_fl_p[4], m_fh_p[4], s_fl_p[4], s_fh_p[4];
  always_ff @(posedge clk) begin
    m_fl_p[0] <= enc_fl;   m_fh_p[0] <= enc_fh;
    s_fl_p[0] <= s_enc_fl; s_fh_p[0] <= s_enc_fh;
    for (int i = 1; i < 4; i++) begin
      m_fl_p[i] <= m_fl_p[i-1]; m_fh_p[i] <= m_fh_p[i-1];
      s_fl_p[i] <= s_fl_p[i-1]; s_fh_p[i] <= s_fh_p[i-1];
    end
  end
  assign enc_low     = {8'd0, m_fl_p[3]};
  assign enc_range   = m_fh_p[3] ^ {{(RW-1){1'b0}}, corrupt};
  assign s_enc_low   = {8'd0, s_fl_p[3]};
  assign s_enc_range = s_fh_p[3] ^ {{(RW-1){1'b0}}, corrupt};

  typedef struct packed {
    logic [RW-1:0] fl;
    logic [RW-1:0] fh;
    logic [SW-1:0] sym;
    logic [SW:0]   ns;
  } drv_t;

  typedef struct {
    int num; int bad_idx; bit corrupt; bit exp_pass; int exp_cnt; bit exp_ffv; int exp_ffi;
  } case_t;

  logic [RW-1:0] b_fl[DEPTH], b_fh[DEPTH];
  logic [SW-1:0] b_sym[DEPTH];
  logic [SW:0]   b_ns[DEPTH];
  drv_t          sb[$];
  int            n_cmp = 0, n_bad = 0;
  case_t         cases[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_all(input int bad_idx);
    for (int a = 0; a < DEPTH; a++) begin
      b_fl[a]  = RW'(100 * (a + 1));
      b_fh[a]  = RW'(50 + 10 * a);
      b_sym[a] = SW'(a);
      b_ns[a]  = (SW + 1)'(a + 1);
      load_en = 1'b1; load_addr = AW'(a);
      load_fl = b_fl[a]; load_fh = b_fh[a]; load_symbol = b_sym[a]; load_nsyms = b_ns[a];
      load_exp_low   = {8'd0, b_fl[a]} + ((a == bad_idx) ? LW'(1) : LW'(0));
      load_exp_range = b_fh[a];
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic run(input int num, input bit disturb, input bit exp_pass, input int exp_cnt,
                     input bit exp_ffv, input int exp_ffi);
    int n, done_at, c;
    bit seen;
    drv_t a, e;
    n       = (num > DEPTH) ? DEPTH : num;
    done_at = (n == 0) ? 0 : (n - 1) * II + LAT + 1;
    num_vectors = (AW + 1)'(num);
    start = 1'b1;
    for (int k = 0; k < n; k++)
      for (int r = 0; r < II; r++) sb.push_back('{b_fl[k], b_fh[k], b_sym[k], b_ns[k]});
    @(negedge clk);
    start = 1'b0;
    c = 0; seen = 1'b0;
    while (1) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{enc_fl, enc_fh, enc_symbol, enc_nsyms};
        chk("enc_drive", a, e);
        chk("enc_reset_run", enc_reset, 0);
      end
      if (n == 0 && c == 0) chk("enc_reset_n0", enc_reset, 1);
      if (n > 0 && c == n * II) chk("enc_zero_drain", {enc_fl, enc_fh}, 0);
      if (disturb && c == 0) begin
        load_en = 1'b1; load_addr = '0; load_fl = 16'hdead; load_fh = 16'hbeef;
        load_exp_low = '0; load_exp_range = '0; start = 1'b1; num_vectors = 1;
      end
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", c, done_at);
        chk("busy_at_done", busy, 0);
        break;
      end
      if (c >= done_at + 20) begin
        chk("done_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      load_en = 1'b0; start = 1'b0;
      c++;
    end
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    chk("pass", pass, exp_pass);
    chk("mismatch_count", mismatch_count, exp_cnt);
    chk("first_fail_valid", first_fail_valid, exp_ffv);
    if (exp_ffv) chk("first_fail_idx", first_fail_idx, exp_ffi);
    chk("sat_done", s_done, seen);
    chk("sat_count", s_cnt, (exp_cnt > 7) ? 7 : exp_cnt);
    chk("sat_ffv", s_ffv, exp_ffv);
    if (exp_ffv) chk("sat_ffi", s_ffi, exp_ffi);
  endtask

  initial begin
    cases[0] = '{3,  -1, 1'b0, 1'b1, 0,  1'b0, 0};
    cases[1] = '{3,   1, 1'b0, 1'b0, 1,  1'b1, 1};
    cases[2] = '{0,  -1, 1'b0, 1'b1, 0,  1'b0, 0};
    cases[3] = '{20, -1, 1'b1, 1'b0, 16, 1'b1, 0};
    cases[4] = '{16, 15, 1'b0, 1'b0, 1,  1'b1, 15};
    cases[5] = '{16, -1, 1'b0, 1'b1, 0,  1'b0, 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_enc_reset", enc_reset, 1);
    chk("rst_enc", {enc_fl, enc_fh, enc_symbol, enc_nsyms}, 0);
    chk("rst_busy_done_pass", {busy, done, pass}, 0);
    chk("rst_count", mismatch_count, 0);
    chk("rst_first_fail", {first_fail_valid, first_fail_idx}, 0);

    foreach (cases[i]) begin
      corrupt = cases[i].corrupt;
      load_all(cases[i].bad_idx);
      run(cases[i].num, 1'b0, cases[i].exp_pass, cases[i].exp_cnt, cases[i].exp_ffv,
          cases[i].exp_ffi);
    end
    corrupt = 1'b0;

    // Abort mid-run with a mismatch already counted, then rerun from retained memory.
    load_all(-1);
    corrupt = 1'b1; num_vectors = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_count_before", mismatch_count, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_count", mismatch_count, 0);
    chk("abort_enc_reset", enc_reset, 1);
    chk("abort_ffv", first_fail_valid, 0);
    repeat (8) @(negedge clk);
    chk("abort_discard", {done, busy, mismatch_count}, 0);
    corrupt = 1'b0;
    run(3, 1'b0, 1'b1, 0, 1'b0, 0);

    // Loads and start pulses while running must be ignored.
    run(3, 1'b1, 1'b1, 0, 1'b0, 0);
    run(3, 1'b0, 1'b1, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arith_vector_checker.md
# arith_vector_checker

Synthesizable vector-replay and self-check engine for the arithmetic encoder pipeline. It holds up to DEPTH stimulus/expected vectors (fl, fh, symbol, nsyms, expected low, expected range) and replays them into the encoder at a programmable issue interval. It compares the encoder's range/low outputs at a fixed pipeline latency and reports the pass/fail status, the mismatch count and the first failing index. It sits beside `arithmetic_encoder` in on-FPGA bring-up builds and replaces file-driven benches for regression runs on hardware.

## Interface
- RANGE_WIDTH, 16, width of fl, fh, range
- LOW_WIDTH, 24, width of low
- SYMBOL_WIDTH, 4, width of symbol; nsyms is SYMBOL_WIDTH+1
- DEPTH, 16, vector memory entries (power of two, ≥2)
- ADDR_WIDTH, 4, log2(DEPTH)
- LATENCY, 4, cycles from the first drive cycle of a vector to the cycle its range/low is sampled (≥1)
- ISSUE_INTERVAL, 2, cycles each vector is held on enc_* (≥1)
- CNT_WIDTH, 8, mismatch counter width
- general_clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- load_en  in  1  write one vector to memory (accepted only in IDLE/DONE)
- load_addr  in  ADDR_WIDTH  write address
- load_fl, load_fh  in  RANGE_WIDTH  stimulus
- load_symbol  in  SYMBOL_WIDTH; load_nsyms  in  SYMBOL_WIDTH+1  stimulus
- load_exp_low  in  LOW_WIDTH; load_exp_range  in  RANGE_WIDTH  expected results
- num_vectors  in  ADDR_WIDTH+1  vectors to replay, sampled with start
- start  in  1  begin replay (accepted only in IDLE/DONE)
- enc_reset  out  1  reset to the encoder
- enc_fl, enc_fh  out  RANGE_WIDTH; enc_symbol  out  SYMBOL_WIDTH; enc_nsyms  out  SYMBOL_WIDTH+1
- enc_range  in  RANGE_WIDTH; enc_low  in  LOW_WIDTH  encoder outputs
- busy  out  1  high in RUN/DRAIN
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 iff mismatch_count==0
- mismatch_count  out  CNT_WIDTH  saturating at all-ones
- first_fail_idx  out  ADDR_WIDTH; first_fail_valid  out  1

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + start: latch N = min(num_vectors, DEPTH) and clear the status. N==0 → DONE, with pass=1. Otherwise → RUN.
- RUN: drives vector k for ISSUE_INTERVAL cycles, k = 0..N-1. After the last cycle of vector N-1 → DRAIN.
- DRAIN: waits until the compare for vector N-1 completes, then → DONE.
- DONE: holds the status until the next start or reset.
- enc_reset is 1 in IDLE and DONE and 0 in RUN/DRAIN. enc_* = 0 outside RUN.
- Compare delay line has LATENCY stages. Each stage carries {valid, idx, exp_low, exp_range}. valid is injected only on the first drive cycle of each vector.
- At the delay-line output, when valid is set, compare enc_range to exp_range and enc_low to exp_low. Any bit difference counts as one mismatch.
- On the first mismatch of a run, set first_fail_valid and capture idx. Later mismatches update only the counter.
- Memory has a single write port and an asynchronous or registered read; the enc_* timing below is binding. The memory is not cleared by reset.
- load_en outside IDLE/DONE is ignored (no write). start while busy is ignored.

## Timing
- Reset values: enc_reset=1, enc_*=0, busy=0, done=0, pass=0, mismatch_count=0, first_fail_idx=0, first_fail_valid=0, delay line invalid.
- S = first RUN cycle, which is the cycle after start is sampled. Vector k is on enc_* in cycles S+k·I through S+k·I+I-1 (I = ISSUE_INTERVAL).
- enc_range/enc_low for vector k are sampled at the edge ending cycle S+k·I+LATENCY.
- Once the final compare is in the counter, done=1 from cycle S+(N-1)·I+LATENCY+1.
- busy falls in the same cycle that done rises.
- Load writes are visible to a start issued in the next cycle.
- reset asserted mid-run: the next cycle is IDLE with all outputs at reset values. In-flight compares are discarded.
- Counter saturation: when at all-ones, further mismatches leave it unchanged. pass stays 0.

## Test plan
- Loopback stub (range=fh, low=fl delayed 4 cycles). Load 3 vectors: fl 100/200/300, fh 50/60/70, with expected values equal. Set N=3, I=2, L=4. → done=1 at S+9, pass=1, mismatch_count=0, first_fail_valid=0.
- Same setup with exp_low[1]=201. → mismatch_count=1, first_fail_idx=1, first_fail_valid=1, pass=0.
- num_vectors=0, start → done=1 the next cycle, pass=1, enc_reset stays 1.
- I=1, DEPTH=16, num_vectors=20, stub mismatching every vector → N clamped to 16, mismatch_count=16, first_fail_idx=0. With CNT_WIDTH=3 the counter saturates at 7.
- reset asserted at S+3 of a 3-vector run → next cycle busy=0, mismatch_count=0, enc_reset=1. Memory contents are retained, and a rerun passes.
- During RUN: load_en to addr 0 with different data, plus start pulse → no memory change, no restart, and the run result matches the first test.
